k12_alu: RTL and testbench

K12_ALU -- requirements
Module: k12_alu

---
 rtl/k12_alu.sv | 156 +++++++++++++++
 tb/tb_k12_alu.sv | 132 +++++++++++++
 2 files changed

// File: rtl/k12_alu.sv
// k12_alu: single-cycle 8-bit ALU with immediate operand select and a selectable condition flag.
// Result and condition are registered; every cycle is independent of the previous one.
module k12_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [15:0] inst,
  output logic [7:0]  res,
  output logic        cond
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;

  typedef struct packed {
    logic          imm_sel;
    logic [2:0]    csel;
    logic [3:0]    func;
    logic [DW-1:0] imm;
  } inst_t;

  typedef enum logic [3:0] {
    FN_ADD  = 4'h0, FN_SUB  = 4'h1, FN_RSB  = 4'h2, FN_AND  = 4'h3,
    FN_OR   = 4'h4, FN_XOR  = 4'h5, FN_MOV  = 4'h6, FN_NOT  = 4'h7,
    FN_SHL  = 4'h8, FN_SHR  = 4'h9, FN_SAR  = 4'hA, FN_ROL  = 4'hB,
    FN_INC  = 4'hC, FN_DEC  = 4'hD, FN_NEG  = 4'hE, FN_SWAP = 4'hF
  } func_e;

  typedef enum logic [2:0] {
    CS_ONE = 3'd0, CS_Z  = 3'd1, CS_NZ = 3'd2, CS_C    = 3'd3,
    CS_NC  = 3'd4, CS_N  = 3'd5, CS_V  = 3'd6, CS_ZERO = 3'd7
  } csel_e;

  inst_t         dec;
  logic [DW-1:0] opb;
  logic [SW-1:0] sh;

  logic [DW:0]     add_w;
  logic [DW:0]     sub_w;
  logic [DW:0]     rsb_w;
  logic [DW:0]     shl_w;
  logic [DW:0]     shr_w;
  logic [DW:0]     sar_w;
  logic [2*DW-1:0] rol_w;

  logic [DW-1:0] r_c;
  logic          c_c;
  logic          v_c;
  logic          z_c;
  logic          n_c;
  logic          cond_c;

  assign dec = inst_t'(inst);
  assign opb = dec.imm_sel ? dec.imm : b;
  assign sh  = opb[SW-1:0];

  // Extended-width datapaths: the extra bit of each catches the carry/borrow or the last bit shifted out.
  assign add_w = {1'b0, a} + {1'b0, opb};
  assign sub_w = {1'b0, a} - {1'b0, opb};
  assign rsb_w = {1'b0, opb} - {1'b0, a};
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;
  assign sar_w = (DW+1)'($signed({a, 1'b0}) >>> sh);
  assign rol_w = {a, a} << sh;

  always_comb begin
    r_c = '0;
    c_c = 1'b0;
    v_c = 1'b0;
    unique case (func_e'(dec.func))
      FN_ADD: begin
        r_c = add_w[DW-1:0];
        c_c = add_w[DW];
        v_c = (a[DW-1] == opb[DW-1]) && (r_c[DW-1] != a[DW-1]);
      end
      FN_SUB: begin
        r_c = sub_w[DW-1:0];
        c_c = ~sub_w[DW];
        v_c = (a[DW-1] != opb[DW-1]) && (r_c[DW-1] != a[DW-1]);
      end
      FN_RSB: begin
        r_c = rsb_w[DW-1:0];
        c_c = ~rsb_w[DW];
        v_c = (opb[DW-1] != a[DW-1]) && (r_c[DW-1] != opb[DW-1]);
      end
      FN_AND: r_c = a & opb;
      FN_OR:  r_c = a | opb;
      FN_XOR: r_c = a ^ opb;
      FN_MOV: r_c = opb;
      FN_NOT: r_c = ~opb;
      FN_SHL: begin
        r_c = shl_w[DW-1:0];
        c_c = shl_w[DW];
      end
      FN_SHR: begin
        r_c = shr_w[DW:1];
        c_c = shr_w[0];
      end
      FN_SAR: begin
        r_c = sar_w[DW:1];
        c_c = sar_w[0];
      end
      FN_ROL: begin
        r_c = rol_w[2*DW-1:DW];
        c_c = (sh != '0) && r_c[0];
      end
      FN_INC: begin
        r_c = a + DW'(1);
        c_c = (a == 8'hFF);
        v_c = (a == 8'h7F);
      end
      FN_DEC: begin
        r_c = a - DW'(1);
        c_c = (a != 8'h00);
        v_c = (a == 8'h80);
      end
      FN_NEG: begin
        r_c = DW'(0) - a;
        c_c = (a == 8'h00);
        v_c = (a == 8'h80);
      end
      FN_SWAP: r_c = {a[3:0], a[7:4]};
      default: r_c = '0;
    endcase
  end

  assign z_c = (r_c == '0);
  assign n_c = r_c[DW-1];

  always_comb begin
    cond_c = 1'b0;
    unique case (csel_e'(dec.csel))
      CS_ONE:  cond_c = 1'b1;
      CS_Z:    cond_c = z_c;
      CS_NZ:   cond_c = ~z_c;
      CS_C:    cond_c = c_c;
      CS_NC:   cond_c = ~c_c;
      CS_N:    cond_c = n_c;
      CS_V:    cond_c = v_c;
      CS_ZERO: cond_c = 1'b0;
      default: cond_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res  <= '0;
      cond <= 1'b0;
    end else begin
      res  <= r_c;
      cond <= cond_c;
    end
  end

endmodule

// File: tb/tb_k12_alu.sv
// Directed-vector bench for k12_alu with hand-computed results and an async reset sequence.
module tb_k12_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] inst = '0;
  logic [7:0]  res;
  logic        cond;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  k12_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .inst  (inst),
    .res   (res),
    .cond  (cond)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] vi, input logic [7:0] eres, input logic econd);
    @(negedge clk);
    a = va;
    b = vb;
    inst = vi;
    @(posedge clk);
    #1;
    check({tag, ".res"}, res, eres);
    check({tag, ".cond"}, 8'(cond), 8'(econd));
  endtask

  typedef struct {
    string       tag;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] vi;
    logic [7:0]  eres;
    logic        econd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add_cz",    8'hFF, 8'h01, 16'h1000, 8'h00, 1'b1});
    vecs.push_back('{"sub_v",     8'h80, 8'h01, 16'h6100, 8'h7F, 1'b1});
    vecs.push_back('{"sub_c",     8'h80, 8'h01, 16'h3100, 8'h7F, 1'b1});
    vecs.push_back('{"xor_imm",   8'h7E, 8'h00, 16'h8501, 8'h7F, 1'b1});
    vecs.push_back('{"shr_c",     8'h81, 8'h01, 16'h3900, 8'h40, 1'b1});
    vecs.push_back('{"sar",       8'h81, 8'h01, 16'h0A00, 8'hC0, 1'b1});
    vecs.push_back('{"rol",       8'h81, 8'h01, 16'h0B00, 8'h03, 1'b1});
    vecs.push_back('{"neg_v",     8'h80, 8'h00, 16'h6E00, 8'h80, 1'b1});
    vecs.push_back('{"swap",      8'hFE, 8'h00, 16'h0F00, 8'hEF, 1'b1});
    vecs.push_back('{"inc_n",     8'hFF, 8'h00, 16'h5C00, 8'h00, 1'b0});
    vecs.push_back('{"add_v",     8'h7F, 8'h01, 16'h6000, 8'h80, 1'b1});
    vecs.push_back('{"add_c",     8'hFF, 8'h01, 16'h3000, 8'h00, 1'b1});
    vecs.push_back('{"sub_nc",    8'h01, 8'h02, 16'h4100, 8'hFF, 1'b1});
    vecs.push_back('{"rsb_c",     8'h05, 8'h03, 16'h3200, 8'hFE, 1'b0});
    vecs.push_back('{"rsb_imm",   8'h01, 8'hAA, 16'hB210, 8'h0F, 1'b1});
    vecs.push_back('{"dec_c0",    8'h00, 8'h00, 16'h3D00, 8'hFF, 1'b0});
    vecs.push_back('{"dec_v",     8'h80, 8'h00, 16'h6D00, 8'h7F, 1'b1});
    vecs.push_back('{"shl_cnt0",  8'h81, 8'h08, 16'h3800, 8'h81, 1'b0});
    vecs.push_back('{"shl_c",     8'h81, 8'h01, 16'h3800, 8'h02, 1'b1});
    vecs.push_back('{"sar7",      8'h80, 8'h07, 16'h3A00, 8'hFF, 1'b0});
    vecs.push_back('{"mov_never", 8'h00, 8'h00, 16'h7600, 8'h00, 1'b0});
    vecs.push_back('{"mov_z",     8'h55, 8'h00, 16'h1600, 8'h00, 1'b1});
    vecs.push_back('{"not_imm",   8'h12, 8'h34, 16'hA7FF, 8'h00, 1'b0});
    vecs.push_back('{"and_n",     8'hF0, 8'h3C, 16'h5300, 8'h30, 1'b0});
    vecs.push_back('{"or_n",      8'hF0, 8'h3C, 16'h5400, 8'hFC, 1'b1});
    vecs.push_back('{"rol4_c",    8'h12, 8'h04, 16'h3B00, 8'h21, 1'b1});
    vecs.push_back('{"shr_cnt0",  8'h81, 8'h00, 16'h3900, 8'h81, 1'b0});
    vecs.push_back('{"inc_v",     8'h7F, 8'h00, 16'h6C00, 8'h80, 1'b1});
    vecs.push_back('{"neg_c",     8'h00, 8'h00, 16'h3E00, 8'h00, 1'b1});

    // Async reset at start-up, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst0.res", res, 8'h00);
    check("rst0.cond", 8'(cond), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].tag, vecs[i].va, vecs[i].vb, vecs[i].vi, vecs[i].eres, vecs[i].econd);

    // Mid-stream reset: drop between edges with a pending op, then release between edges.
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    inst = 16'h0000;
    #2 rst_n = 1'b0;
    #1;
    check("rst1.res", res, 8'h00);
    check("rst1.cond", 8'(cond), 8'h00);
    @(posedge clk);
    #1;
    check("rst_hold.res", res, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rel.res", res, 8'h00);
    check("rel.cond", 8'(cond), 8'h00);
    @(posedge clk);
    #1;
    check("post_rel.res", res, 8'h46);
    check("post_rel.cond", 8'(cond), 8'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
